// File: rtl/cordic_sqrt_pkg.sv
// Shared constants, FSM encoding and repeat-index helper for the CORDIC square-root engine.
package cordic_sqrt_pkg;

  localparam int DATA_W = 22;
  localparam int FRAC_W = 20;
  localparam int N_ITER = 16;
  localparam int IDX_W  = 5;

  localparam logic [DATA_W-1:0]        SEED_QUARTER = 22'h040000;
  localparam logic [DATA_W-1:0]        A_MIN        = 22'h010000;
  localparam logic [DATA_W-1:0]        A_MAX        = 22'h180000;
  localparam logic signed [DATA_W-1:0] KINV         = 22'sd1266152;

  localparam logic [IDX_W-1:0] REPEAT_IDX0 = 5'd4;
  localparam logic [IDX_W-1:0] REPEAT_IDX1 = 5'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_COMP,
    ST_DONE
  } state_t;

  // Hyperbolic CORDIC only converges if these shift indices are executed twice.
  function automatic logic is_repeat_idx(input logic [IDX_W-1:0] idx);
    return (idx == REPEAT_IDX0) || (idx == REPEAT_IDX1);
  endfunction

endpackage

// File: rtl/cordic_hyp_rot.sv
// Combinational hyperbolic micro-rotation: x' = x + d*(y>>>i), y' = y + d*(x>>>i).
module cordic_hyp_rot
  import cordic_sqrt_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_y,
  input  logic        [IDX_W-1:0]  i_shift,
  input  logic                     i_d_pos,
  output logic signed [DATA_W-1:0] o_x,
  output logic signed [DATA_W-1:0] o_y
);

  logic signed [DATA_W-1:0] w_x_sh;
  logic signed [DATA_W-1:0] w_y_sh;

  assign w_x_sh = i_x >>> i_shift;
  assign w_y_sh = i_y >>> i_shift;

  assign o_x = i_d_pos ? (i_x + w_y_sh) : (i_x - w_y_sh);
  assign o_y = i_d_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);

endmodule

// File: rtl/cordic_sqrt_engine.sv
// Iterative hyperbolic-vectoring CORDIC sqrt, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that removes the K_h gain from the result.
module cordic_sqrt_engine
  import cordic_sqrt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [DATA_W-1:0] r_a;
  logic signed [DATA_W-1:0] r_x;
  logic signed [DATA_W-1:0] r_y;
  logic        [IDX_W-1:0]  r_idx;
  logic                     r_rep;
  logic                     r_bad;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;
  logic        [DATA_W-1:0] r_result;

  logic signed [DATA_W-1:0] w_x_rot;
  logic signed [DATA_W-1:0] w_y_rot;
  logic                     w_in_range;
  logic                     w_hold_idx;
  logic                     w_last;

  assign w_in_range = (a_in >= A_MIN) && (a_in <= A_MAX);
  assign w_hold_idx = is_repeat_idx(r_idx) && !r_rep;
  assign w_last     = (r_idx == IDX_W'(N_ITER));

  cordic_hyp_rot u_rot (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_shift (r_idx),
    .i_d_pos (r_y[DATA_W-1]),
    .o_x     (w_x_rot),
    .o_y     (w_y_rot)
  );

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] w_prod_rnd;
  logic signed [DATA_W-1:0]   w_x_comp;

  assign w_prod     = r_x * KINV;
  assign w_prod_rnd = w_prod + (2*DATA_W)'(1 << (FRAC_W - 1));
  assign w_x_comp   = w_prod_rnd[FRAC_W +: DATA_W];
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = w_in_range ? ST_LOAD : ST_DONE;
      ST_LOAD: w_state_nxt = ST_ITER;
      ST_ITER: begin
`ifdef CORDIC_GAIN_COMP_EN
        if (w_last && !w_hold_idx) w_state_nxt = ST_COMP;
`else
        if (w_last && !w_hold_idx) w_state_nxt = ST_DONE;
`endif
      end
      ST_COMP: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_idx    <= '0;
      r_rep    <= 1'b0;
      r_bad    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_a    <= a_in;
            r_bad  <= !w_in_range;
          end
        end
        ST_LOAD: begin
          r_x   <= r_a + SEED_QUARTER;
          r_y   <= r_a - SEED_QUARTER;
          r_idx <= IDX_W'(1);
          r_rep <= 1'b0;
        end
        ST_ITER: begin
          r_x <= w_x_rot;
          r_y <= w_y_rot;
          if (w_hold_idx) begin
            r_rep <= 1'b1;
          end else begin
            r_rep <= 1'b0;
            r_idx <= r_idx + IDX_W'(1);
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_COMP: r_x <= w_x_comp;
`endif
        ST_DONE: begin
          r_result <= r_bad ? '0 : r_x;
          r_err    <= r_bad;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;

endmodule

// File: tb/tb_cordic_sqrt_engine.sv
// Scoreboard bench for cordic_sqrt_engine (default build: raw K_h-scaled result, latency 20).
module tb_cordic_sqrt_engine;

  localparam int W     = 22;
  localparam int LAT   = 20;
  localparam int TOL   = 8;
  localparam int AMIN  = 32'h010000;
  localparam int AMAX  = 32'h180000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  cordic_sqrt_engine dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a_in   (a_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          exp_res;
    bit          exp_err;
    int unsigned done_edge;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned cyc    = 0;
  int unsigned busy_from = 0;
  int unsigned busy_to   = 0;
  int unsigned next_free = 0;
  int unsigned last_acc  = 0;
  real         k_h;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp, input int tol);
    int diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    n_chk++;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) +/- %0d at edge %0d",
                  name, act, act, exp, exp, tol, cyc);
  endtask

  // Ideal sqrt scaled by the hyperbolic gain of the 18-rotation sequence.
  function automatic int model_sqrt(input int a);
    real r;
    r = k_h * $sqrt(real'(a) / 1048576.0) * 1048576.0;
    return $rtoi(r + 0.5);
  endfunction

  // Monitor: pops the scoreboard whenever done is presented.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check("busy", int'(busy), int'(cyc >= busy_from && cyc < busy_to), 0);
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: done=1 with empty scoreboard at edge %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("result", int'(result), mon_e.exp_res, mon_e.exp_err ? 0 : TOL);
          check("err", int'(err), int'(mon_e.exp_err), 0);
          check("latency", int'(cyc), int'(mon_e.done_edge), 0);
        end
      end
    end
  end

  task automatic issue(input int a, input bit hold);
    exp_t        e;
    bit          bad;
    int unsigned lat;
    @(negedge clk);
    while (cyc + 1 < next_free) @(negedge clk);
    a_in  = W'(a);
    start = 1'b1;
    last_acc    = cyc + 1;
    bad         = (a < AMIN) || (a > AMAX);
    lat         = bad ? 1 : LAT;
    e.exp_res   = bad ? 0 : model_sqrt(a);
    e.exp_err   = bad;
    e.done_edge = last_acc + lat;
    sb.push_back(e);
    busy_from = last_acc;
    busy_to   = last_acc + lat;
    next_free = last_acc + lat + 1;
    @(posedge clk);
    #1;
    a_in = W'($urandom);
    if (!hold) start = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, int'(busy), 0, 0);
    check({tag, "_done"}, int'(done), 0, 0);
    check({tag, "_result"}, int'(result), 0, 0);
    check({tag, "_err"}, int'(err), 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    real p;
    int  wait_cnt;
    k_h = 1.0;
    p   = 1.0;
    for (int i = 1; i <= 16; i++) begin
      p   = p / 4.0;
      k_h = k_h * $sqrt(1.0 - p);
      if (i == 4 || i == 13) k_h = k_h * $sqrt(1.0 - p);
    end

    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    #3;
    check_cleared("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // T1/T2 and range boundaries
    issue(32'h100000, 0);
    issue(32'h040000, 0);
    issue(AMIN, 0);
    issue(AMAX, 0);
    // T3 out-of-range operands
    issue(32'h00F000, 0);
    issue(32'h190000, 0);
    issue(AMIN - 1, 0);
    issue(AMAX + 1, 0);

    // T4 start held high across back-to-back operations
    issue($urandom_range(AMAX, AMIN), 1);
    issue($urandom_range(AMAX, AMIN), 1);
    issue(32'h00A000, 1);
    issue($urandom_range(AMAX, AMIN), 1);
    issue($urandom_range(AMAX, AMIN), 0);

    // T5 reset in the middle of the iterations
    issue(32'h0C0000, 0);
    while (cyc < last_acc + 8) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check_cleared("abort");
    sb.delete();
    busy_from = 0;
    busy_to   = 0;
    next_free = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("post_abort");
    issue(32'h090000, 0);

    // T6 random sweep of valid operands
    for (int n = 0; n < 256; n++) issue($urandom_range(AMAX, AMIN), 0);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 100) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    check("pending", sb.size(), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
